spine_switch: RTL

SPINE_SWITCH -- requirements
Module: spine_switch

---
 rtl/noc_pkg.sv | 39 +++
 rtl/noc_fifo.sv | 74 +++++++
 rtl/spine_switch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared constants, flit header type and counter helpers for the spine switch.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned GROUP_MSB = 5;
    localparam int unsigned GROUP_LSB = 2;
    localparam int unsigned GROUP_W   = GROUP_MSB - GROUP_LSB + 1;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned EVT_W     = 3;

    // Routing part of a flit: destination carried through, plus the looked-up output.
    // The payload width is a module parameter, so the full flit
    // {data, dest, out_port} is assembled around this header in spine_switch.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [PORT_W-1:0] out_port;
    } flit_hdr_t;

    // Number of set bits in a per-port event vector.
    function automatic logic [EVT_W-1:0] count_ones(input logic [NUM_PORTS-1:0] v);
        logic [EVT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            n = n + EVT_W'(v[i]);
        end
        return n;
    endfunction

    // Saturating add of an event count onto an 8-bit counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [EVT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO with registered full/empty flags; pushes while full are ignored.
module noc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic [AW:0]      w_count_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    // Occupancy after this edge, used to register the status flags.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + (AW + 1)'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - (AW + 1)'(1);
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW + 1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/spine_switch.sv
// 4-port spine switch: input sampling, group routing, per-input FIFOs,
// per-output round-robin / fixed-priority arbitration and registered outputs.
module spine_switch
    import noc_pkg::*;
#(
    parameter int unsigned                  SPINE_ID    = 1,
    parameter int unsigned                  DWIDTH      = 16,
    parameter int unsigned                  FIFO_DEPTH  = 4,
    parameter logic [NUM_PORTS*GROUP_W-1:0] LEAF_GROUPS = {4'b1011, 4'b1010, 4'b1001, 4'b1000}
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arb_enable,
    input  logic [NUM_PORTS*DWIDTH-1:0] leaf_in_data,
    input  logic [NUM_PORTS-1:0]        leaf_in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] leaf_in_dest,
    output logic [NUM_PORTS*DWIDTH-1:0] leaf_out_data,
    output logic [NUM_PORTS-1:0]        leaf_out_valid,
    output logic [NUM_PORTS*ADDR_W-1:0] leaf_out_dest,
    output logic [NUM_PORTS-1:0]        fifo_full,
    output logic [NUM_PORTS-1:0]        fifo_empty,
    output logic [CNT_W-1:0]            drop_count,
    output logic [CNT_W-1:0]            unroutable_count
);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        flit_hdr_t         hdr;
    } flit_t;

    localparam int unsigned FLIT_W = $bits(flit_t);

    // SPINE_ID is an instance tag only and takes no part in routing.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spine_switch %0d: FIFO_DEPTH must be a power of two >= 2", SPINE_ID);
    end

    logic [NUM_PORTS-1:0]        r_in_valid;
    logic [NUM_PORTS*DWIDTH-1:0] r_in_data;
    logic [NUM_PORTS*ADDR_W-1:0] r_in_dest;
    logic [NUM_PORTS*DWIDTH-1:0] r_out_data;
    logic [NUM_PORTS-1:0]        r_out_valid;
    logic [NUM_PORTS*ADDR_W-1:0] r_out_dest;
    logic [PORT_W-1:0]           r_last_grant [NUM_PORTS];
    logic [CNT_W-1:0]            r_drop_cnt;
    logic [CNT_W-1:0]            r_unr_cnt;

    logic [NUM_PORTS-1:0]        w_hit;
    logic [PORT_W-1:0]           w_route [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_push;
    logic [NUM_PORTS-1:0]        w_drop;
    logic [NUM_PORTS-1:0]        w_unroutable;
    logic [NUM_PORTS-1:0]        w_pop;
    logic [NUM_PORTS-1:0]        w_full;
    logic [NUM_PORTS-1:0]        w_empty;
    flit_t                       w_wflit [NUM_PORTS];
    flit_t                       w_head  [NUM_PORTS];
    logic [NUM_PORTS-1:0]        w_gnt_valid;
    logic [PORT_W-1:0]           w_gnt_idx [NUM_PORTS];

    // Input sampling stage; valids are held low during reset so inputs are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_valid <= '0;
        end else begin
            r_in_valid <= leaf_in_valid;
        end
    end

    // Payload and destination capture alongside the valids.
    always_ff @(posedge clk) begin
        r_in_data <= leaf_in_data;
        r_in_dest <= leaf_in_dest;
    end

    // Route lookup: first output whose owned group matches dest[5:2].
    always_comb begin
        w_hit = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_route[p] = '0;
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                if (!w_hit[p] &&
                    LEAF_GROUPS[q*GROUP_W +: GROUP_W] == r_in_dest[p*ADDR_W + GROUP_LSB +: GROUP_W]) begin
                    w_hit[p]   = 1'b1;
                    w_route[p] = PORT_W'(q);
                end
            end
        end
    end

    // FIFO write requests, drop and unroutable events.
    always_comb begin
        w_push       = r_in_valid & w_hit;
        w_drop       = w_push & w_full;
        w_unroutable = r_in_valid & ~w_hit;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_wflit[p].data         = r_in_data[p*DWIDTH +: DWIDTH];
            w_wflit[p].hdr.dest     = r_in_dest[p*ADDR_W +: ADDR_W];
            w_wflit[p].hdr.out_port = w_route[p];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        noc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[p]),
            .i_wdata (w_wflit[p]),
            .i_pop   (w_pop[p]),
            .o_rdata (w_head[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p])
        );
    end

    // Per-output arbitration over FIFO heads; the winning FIFO pops.
    always_comb begin
        logic [NUM_PORTS-1:0] w_req;
        logic [PORT_W-1:0]    w_idx;
        w_gnt_valid = '0;
        w_pop       = '0;
        w_req       = '0;
        w_idx       = '0;
        for (int unsigned q = 0; q < NUM_PORTS; q++) begin
            w_gnt_idx[q] = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                w_req[p] = !w_empty[p] && (w_head[p].hdr.out_port == PORT_W'(q));
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                w_idx = arb_enable ? PORT_W'(r_last_grant[q] + PORT_W'(1) + PORT_W'(i))
                                   : PORT_W'(i);
                if (!w_gnt_valid[q] && w_req[w_idx]) begin
                    w_gnt_valid[q] = 1'b1;
                    w_gnt_idx[q]   = w_idx;
                end
            end
            if (w_gnt_valid[q]) begin
                w_pop[w_gnt_idx[q]] = 1'b1;
            end
        end
    end

    // Output registers and last-grant pointers; data holds when no grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                r_last_grant[q] <= PORT_W'(NUM_PORTS - 1);
            end
        end else begin
            r_out_valid <= w_gnt_valid;
            for (int unsigned q = 0; q < NUM_PORTS; q++) begin
                if (w_gnt_valid[q]) begin
                    r_out_data[q*DWIDTH +: DWIDTH] <= w_head[w_gnt_idx[q]].data;
                    r_out_dest[q*ADDR_W +: ADDR_W] <= w_head[w_gnt_idx[q]].hdr.dest;
                    r_last_grant[q]                <= w_gnt_idx[q];
                end
            end
        end
    end

    // Saturating event counters; several ports may add in one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
            r_unr_cnt  <= '0;
        end else begin
            r_drop_cnt <= sat_add(r_drop_cnt, count_ones(w_drop));
            r_unr_cnt  <= sat_add(r_unr_cnt, count_ones(w_unroutable));
        end
    end

    assign leaf_out_data    = r_out_data;
    assign leaf_out_valid   = r_out_valid;
    assign leaf_out_dest    = r_out_dest;
    assign fifo_full        = w_full;
    assign fifo_empty       = w_empty;
    assign drop_count       = r_drop_cnt;
    assign unroutable_count = r_unr_cnt;

endmodule
